lsu_aligned: RTL

Parametrised load/store unit sitting between execute and the data cache, successor to the single-cycle combinational LSU. Accepts one memory op at a time from execute, drives a word-aligned dcache request with byte-lane steering from the low address bits, holds the request stable until the cache accepts it, and returns an aligned, sign- or zero-extended load result with a one-cycle `done` pulse. Supports 32- or 64-bit datapaths, flags misaligned and illegal-size accesses instead of issuing them, and has a registered FSM in place of the combinational handshake.

---
 rtl/lsu_aligned_pkg.sv | 24 ++
 rtl/lsu_aligned_if.sv | 33 +++
 rtl/lsu_aligned_lane_align.sv | 64 ++++++
 rtl/lsu_aligned.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lsu_aligned_pkg.sv
// Shared types and constants for the aligned load/store unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package lsu_aligned_pkg;

  typedef logic [6:0]  opcode_t;
  typedef logic [2:0]  func3_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [63:0] data64_t;
  typedef logic [3:0]  byte_en_t;
  typedef logic [7:0]  byte_en64_t;

  localparam opcode_t OP_LOAD  = 7'b0000011;
  localparam opcode_t OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} lsu_state_e;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/lsu_aligned_if.sv
// Execute-side and dcache-side bundles of the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready toward execute, valid/ready toward the cache.
interface lsu_exec_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] alu_out;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   rdata;
  logic              done;
  logic              fault;

  modport master (output req_valid, opcode, func3, alu_out, rs2,
                  input  req_ready, rdata, done, fault);
  modport slave  (input  req_valid, opcode, func3, alu_out, rs2,
                  output req_ready, rdata, done, fault);
endinterface

interface lsu_dcache_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] byte_enable;
  logic              ready;
  logic [XLEN-1:0]   dcache_rdata;

  modport master (output valid, addr, wdata, byte_enable,
                  input  ready, dcache_rdata);
  modport slave  (input  valid, addr, wdata, byte_enable,
                  output ready, dcache_rdata);
endinterface

// File: rtl/lsu_aligned_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load shift + extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_lane_align
  import lsu_aligned_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BE_W = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0] off,
  input  lsu_size_e        size,
  input  logic             is_unsigned,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  ld_raw,
  output logic [BE_W-1:0]  byte_enable,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [BE_W-1:0] lane_mask;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] shifted;
  logic            sign;

  // Per-size lane mask, replicated store data, load field mask and its sign bit.
  always_comb begin
    lane_mask = '0;
    mask      = '0;
    wdata     = st_data;
    shifted   = ld_raw >> {off, 3'b000};
    sign      = 1'b0;
    case (size)
      SZ_B: begin
        lane_mask[0] = 1'b1;
        mask[7:0]    = '1;
        wdata        = {BE_W{st_data[7:0]}};
        sign         = shifted[7];
      end
      SZ_H: begin
        lane_mask[1:0] = '1;
        mask[15:0]     = '1;
        wdata          = {(BE_W/2){st_data[15:0]}};
        sign           = shifted[15];
      end
      SZ_W: begin
        lane_mask[3:0] = '1;
        mask[31:0]     = '1;
        wdata          = {(XLEN/32){st_data[31:0]}};
        sign           = shifted[31];
      end
      default: begin
        lane_mask = '1;
        mask      = '1;
        wdata     = st_data;
        sign      = shifted[XLEN-1];
      end
    endcase
    byte_enable = lane_mask << off;
    rdata       = shifted & mask;
    if (!is_unsigned && sign) rdata = rdata | ~mask;
  end

endmodule

// File: rtl/lsu_aligned.sv
// Multi-cycle LSU: accepts one op, issues an aligned dcache request, returns extended load data.
// Latency: accept at 0, valid from 1, done one cycle after ready; faults/non-memory done at 1.
// Backpressure: req_ready only in IDLE; request held stable until the cache raises ready.
module lsu_aligned
  import lsu_aligned_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = XLEN / 8
) (
  input logic          clk,
  input logic          rst,
  lsu_exec_if.slave    ex,
  lsu_dcache_if.master dc
);

  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e        state_q, state_d;
  opcode_t           opcode_q, opcode_d;
  func3_t            func3_q, func3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  // Decode of the op currently offered by execute.
  lsu_size_e        in_size;
  logic [OFF_W-1:0] in_off;
  logic [3:0]       in_nb_m1;
  logic             in_misalign, in_illegal, in_fault;

  assign in_size     = lsu_size_e'(ex.func3[1:0]);
  assign in_off      = ex.alu_out[OFF_W-1:0];
  assign in_nb_m1    = (4'd1 << ex.func3[1:0]) - 4'd1;
  assign in_misalign = ((4'(in_off)) & in_nb_m1) != 4'd0;
  assign in_illegal  = (in_size == SZ_D) && ((XLEN == 32) || ex.func3[2]);
  assign in_fault    = is_mem_op(ex.opcode) && (in_misalign || in_illegal);

  // The aligner steers store data at accept time and aligns load data in REQ.
  logic [OFF_W-1:0] la_off;
  lsu_size_e        la_size;
  logic             la_uns;
  logic [BE_W-1:0]  la_be;
  logic [XLEN-1:0]  la_wdata, la_rdata;

  assign la_off  = (state_q == IDLE) ? in_off : off_q;
  assign la_size = (state_q == IDLE) ? in_size : lsu_size_e'(func3_q[1:0]);
  assign la_uns  = (state_q == IDLE) ? ex.func3[2] : func3_q[2];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off         (la_off),
    .size        (la_size),
    .is_unsigned (la_uns),
    .st_data     (ex.rs2),
    .ld_raw      (dc.dcache_rdata),
    .byte_enable (la_be),
    .wdata       (la_wdata),
    .rdata       (la_rdata)
  );

  // Next-state and registered-output computation for the IDLE/REQ/RESP sequence.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    func3_d  = func3_q;
    off_d    = off_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex.req_valid) begin
          opcode_d = ex.opcode;
          func3_d  = ex.func3;
          off_d    = in_off;
          rdata_d  = '0;
          if (is_mem_op(ex.opcode) && !in_fault) begin
            state_d = REQ;
            valid_d = 1'b1;
            addr_d  = ex.alu_out & ~ADDR_W'(BE_W - 1);
            wdata_d = (ex.opcode == OP_STORE) ? la_wdata : '0;
            be_d    = (ex.opcode == OP_STORE) ? la_be : '0;
          end else begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = in_fault;
          end
        end
      end
      REQ: begin
        if (dc.ready) begin
          state_d = RESP;
          valid_d = 1'b0;
          done_d  = 1'b1;
          rdata_d = (opcode_q == OP_LOAD) ? la_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending cache request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      func3_q  <= '0;
      off_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      func3_q  <= func3_d;
      off_q    <= off_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign ex.req_ready   = (state_q == IDLE);
  assign ex.rdata       = rdata_q;
  assign ex.done        = done_q;
  assign ex.fault       = fault_q;
  assign dc.valid       = valid_q;
  assign dc.addr        = addr_q;
  assign dc.wdata       = wdata_q;
  assign dc.byte_enable = be_q;

endmodule
